dfi_phyupd_requester: RTL
=========================

# dfi_phyupd_requester

PHY-side DFI update requester: converts an internal PHY update request into the DFI `phyupd_req`/`phyupd_type` handshake toward the memory controller, and grants the PHY an update window once `phyupd_ack` is returned. It checks response time (tphyupd_resp) and update duration (tphyupd_typeN) and raises sticky error flags. It sits between the PHY calibration/update engine and the DFI boundary monitored by the DFI agent.

## Interface
- T_RESP, 16, max cycles from `phyupd_req` rise to `phyupd_ack` (tphyupd_resp)
- T_UPD0, 32, max update duration for type 0, cycles
- T_UPD1, 64, type 1
- T_UPD2, 128, type 2
- T_UPD3, 256, type 3
- CNT_W, 9, counter width; must hold max(T_RESP, T_UPDn)+1
- clock  in  1  sole clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- upd_start  in  1  single-cycle request from PHY update engine
- upd_type  in  2  update type, sampled with `upd_start`
- upd_done  in  1  PHY finished update; level, sampled only in UPD
- err_clr  in  1  clears all sticky flags
- phyupd_ack  in  1  DFI ack from controller
- phyupd_req  out  1  DFI request, registered
- phyupd_type  out  2  DFI type, registered, stable while req high
- upd_granted  out  1  PHY may update; registered
- busy  out  1  state != IDLE
- resp_timeout  out  1  sticky: ack not seen within T_RESP
- dur_overrun  out  1  sticky: update hit T_UPD limit
- proto_err  out  1  sticky: ack dropped while req high, or ack high in IDLE

## Operation
- States: IDLE, REQ, UPD, DROP.
- IDLE: `upd_start`=1 -> REQ; latch `upd_type` into `phyupd_type`; `phyupd_req`<=1; resp counter<=0. `upd_start` in any other state is ignored (no queueing).
- REQ: counter increments each cycle ack=0. Ack=1 -> UPD, `upd_granted`<=1, dur counter<=1. Counter reaches T_RESP with ack=0 -> set `resp_timeout`, remain in REQ holding req (req is never withdrawn before ack).
- UPD: `upd_done`=1 -> DROP. Dur counter == T_UPD[type] and `upd_done`=0 -> set `dur_overrun`, DROP. Both in same cycle -> DROP, no overrun. Ack=0 in UPD -> set `proto_err`, DROP.
- DROP: `phyupd_req`=0, `upd_granted`=0. Ack=0 -> IDLE. Req never re-asserts while ack high.
- Ack=1 sampled in IDLE -> set `proto_err`.
- Counters saturate at 2^CNT_W-1; no wrap.
- `err_clr` clears flags; set and clear in same cycle -> set wins.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, `phyupd_type`=0; assertion mid-operation drops req/granted immediately (async).
- `upd_start` at cycle n -> `phyupd_req`, `busy` high at n+1.
- Ack first sampled high at k -> `upd_granted` high at k+1.
- `upd_done` sampled at m -> req and granted low at m+1.
- Req rise = cycle 0; ack absent on samples 0..T_RESP -> `resp_timeout` high at T_RESP+1.
- First UPD cycle = dur 1; no done through dur T_UPDn -> req low next cycle, `dur_overrun` high same cycle.
- DROP -> IDLE on first cycle ack sampled low; earliest next req is 2 cycles after req fall.
- `busy` low the cycle after DROP exits.

## Structure
- Package `dfi_phyupd_pkg`: state enum, `phyupd_type_e` (TYPE0..TYPE3), default T_RESP/T_UPDn constants, `tupd_limit(type)` function.
- One sub-module `dfi_sat_counter` (clear, enable, saturating, CNT_W), instanced for resp and duration counts.

## Test plan
- Start type 1, ack after 3 cycles, done after 10 granted cycles -> req 1 at n+1, granted at ack+1, req low at done+1, no flags.
- Ack withheld 20 cycles, T_RESP=16 -> `resp_timeout` at req cycle 17, req held high until ack, then normal update.
- Type 0, done never asserted -> req drops after 32 granted cycles, `dur_overrun`=1; `err_clr` -> 0.
- Ack dropped mid-UPD, and ack pulsed in IDLE -> `proto_err`=1, FSM to DROP then IDLE; no req re-rise while ack high.
- `upd_start` during UPD and done+limit same cycle -> start ignored, no overrun; async reset mid-REQ -> req 0 immediately, all flags 0.

Source files
------------

// File: rtl/dfi_phyupd_pkg.sv
// Shared types, default timing limits and the update-duration lookup for the
// DFI PHY update requester.
package dfi_phyupd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_UPD  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TYPE0 = 2'd0,
    TYPE1 = 2'd1,
    TYPE2 = 2'd2,
    TYPE3 = 2'd3
  } phyupd_type_e;

  localparam int unsigned CNT_W_DEF  = 32'd9;
  localparam int unsigned T_RESP_DEF = 32'd16;
  localparam int unsigned T_UPD0_DEF = 32'd32;
  localparam int unsigned T_UPD1_DEF = 32'd64;
  localparam int unsigned T_UPD2_DEF = 32'd128;
  localparam int unsigned T_UPD3_DEF = 32'd256;

  // Maximum update duration in cycles for the given update type.
  function automatic int unsigned tupd_limit(
    input phyupd_type_e t,
    input int unsigned  t0 = T_UPD0_DEF,
    input int unsigned  t1 = T_UPD1_DEF,
    input int unsigned  t2 = T_UPD2_DEF,
    input int unsigned  t3 = T_UPD3_DEF
  );
    case (t)
      TYPE0:   return t0;
      TYPE1:   return t1;
      TYPE2:   return t2;
      TYPE3:   return t3;
      default: return t3;
    endcase
  endfunction

endpackage

// File: rtl/dfi_phyupd_if.sv
// PHY-engine and DFI-side signals of the PHY update requester.
// master: the requester itself; slave: its environment (PHY engine + controller).
interface dfi_phyupd_if;
  logic       upd_start;
  logic [1:0] upd_type;
  logic       upd_done;
  logic       err_clr;
  logic       phyupd_ack;
  logic       phyupd_req;
  logic [1:0] phyupd_type;
  logic       upd_granted;
  logic       busy;
  logic       resp_timeout;
  logic       dur_overrun;
  logic       proto_err;

  modport master (
    input  upd_start, upd_type, upd_done, err_clr, phyupd_ack,
    output phyupd_req, phyupd_type, upd_granted, busy,
           resp_timeout, dur_overrun, proto_err
  );

  modport slave (
    output upd_start, upd_type, upd_done, err_clr, phyupd_ack,
    input  phyupd_req, phyupd_type, upd_granted, busy,
           resp_timeout, dur_overrun, proto_err
  );
endinterface

// File: rtl/dfi_sat_counter.sv
// Up-counter with synchronous clear that holds at its all-ones value
// instead of wrapping.
module dfi_sat_counter #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear has priority, increment stops at the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (en && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/dfi_phyupd_requester.sv
// PHY-side DFI update requester: raises phyupd_req on an engine request,
// grants the update window on phyupd_ack, releases on done or duration limit,
// and keeps sticky flags for response timeout, overrun and protocol errors.
module dfi_phyupd_requester
  import dfi_phyupd_pkg::*;
#(
  parameter int unsigned T_RESP = T_RESP_DEF,
  parameter int unsigned T_UPD0 = T_UPD0_DEF,
  parameter int unsigned T_UPD1 = T_UPD1_DEF,
  parameter int unsigned T_UPD2 = T_UPD2_DEF,
  parameter int unsigned T_UPD3 = T_UPD3_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  dfi_phyupd_if.master   bus
);

  state_e           state_r;
  state_e           state_nxt_s;
  phyupd_type_e     type_r;
  phyupd_type_e     type_nxt_s;
  logic [CNT_W-1:0] resp_cnt_s;
  logic [CNT_W-1:0] dur_cnt_s;
  logic [CNT_W-1:0] resp_lim_s;
  logic [CNT_W-1:0] upd_lim_s;
  logic             resp_clr_s;
  logic             resp_en_s;
  logic             dur_clr_s;
  logic             dur_en_s;
  logic             req_nxt_s;
  logic             granted_nxt_s;
  logic             busy_nxt_s;
  logic             resp_to_set_s;
  logic             dur_ovr_set_s;
  logic             proto_set_s;
  logic             req_r;
  logic             granted_r;
  logic             busy_r;
  logic             resp_to_r;
  logic             dur_ovr_r;
  logic             proto_r;

  assign resp_lim_s = CNT_W'(T_RESP);
  assign upd_lim_s  = CNT_W'(tupd_limit(type_r, T_UPD0, T_UPD1, T_UPD2, T_UPD3));

  // Response counter: zero on the first REQ cycle, counts cycles without ack.
  assign resp_clr_s = (state_r != ST_REQ);
  assign resp_en_s  = (state_r == ST_REQ) && !bus.phyupd_ack;

  // Duration counter: reads 1 on the first UPD cycle, held at 0 elsewhere.
  assign dur_clr_s  = (state_nxt_s != ST_UPD);
  assign dur_en_s   = (state_nxt_s == ST_UPD);

  dfi_sat_counter #(.CNT_W(CNT_W)) u_resp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (resp_clr_s),
    .en    (resp_en_s),
    .cnt   (resp_cnt_s)
  );

  dfi_sat_counter #(.CNT_W(CNT_W)) u_dur_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dur_clr_s),
    .en    (dur_en_s),
    .cnt   (dur_cnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a request is never withdrawn before ack arrives.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.upd_start) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.phyupd_ack) begin
          state_nxt_s = ST_UPD;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_UPD: begin
        if (!bus.phyupd_ack || bus.upd_done || (dur_cnt_s >= upd_lim_s)) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_UPD;
        end
      end
      ST_DROP: begin
        if (!bus.phyupd_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output and flag-set decode for the next cycle.
  always_comb begin
    req_nxt_s     = (state_nxt_s == ST_REQ) || (state_nxt_s == ST_UPD);
    granted_nxt_s = (state_nxt_s == ST_UPD);
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    if ((state_r == ST_IDLE) && bus.upd_start) begin
      type_nxt_s = phyupd_type_e'(bus.upd_type);
    end else begin
      type_nxt_s = type_r;
    end
    resp_to_set_s = (state_r == ST_REQ) && !bus.phyupd_ack && (resp_cnt_s >= resp_lim_s);
    // Done in the same cycle as the limit wins: no overrun.
    dur_ovr_set_s = (state_r == ST_UPD) && !bus.upd_done && (dur_cnt_s >= upd_lim_s);
    proto_set_s   = ((state_r == ST_IDLE) && bus.phyupd_ack) ||
                    ((state_r == ST_UPD) && !bus.phyupd_ack);
  end

  // Registered outputs and sticky flags (set wins over a same-cycle clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r     <= 1'b0;
      granted_r <= 1'b0;
      busy_r    <= 1'b0;
      type_r    <= TYPE0;
      resp_to_r <= 1'b0;
      dur_ovr_r <= 1'b0;
      proto_r   <= 1'b0;
    end else begin
      req_r     <= req_nxt_s;
      granted_r <= granted_nxt_s;
      busy_r    <= busy_nxt_s;
      type_r    <= type_nxt_s;
      resp_to_r <= resp_to_set_s | (resp_to_r & ~bus.err_clr);
      dur_ovr_r <= dur_ovr_set_s | (dur_ovr_r & ~bus.err_clr);
      proto_r   <= proto_set_s   | (proto_r   & ~bus.err_clr);
    end
  end

  assign bus.phyupd_req   = req_r;
  assign bus.phyupd_type  = type_r;
  assign bus.upd_granted  = granted_r;
  assign bus.busy         = busy_r;
  assign bus.resp_timeout = resp_to_r;
  assign bus.dur_overrun  = dur_ovr_r;
  assign bus.proto_err    = proto_r;

endmodule
